// File: rtl/rr_reg_bank_arbiter.sv
// rr_reg_bank_arbiter
// Register bank shared by NREQ write requesters. A round-robin arbiter grants
// at most one write per cycle. An owner may lock the bus for a bounded burst of
// MAX_LOCK writes. Reads are asynchronous, and a write becomes visible only after
// its commit edge.
module rr_reg_bank_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 4,
  parameter int MAX_LOCK = 4,
  localparam int AW      = $clog2(DEPTH),
  localparam int OW      = $clog2(NREQ),
  localparam int CW      = $clog2(MAX_LOCK + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*AW-1:0]    wr_addr,
  input  logic [NREQ*WIDTH-1:0] wr_data,
  output logic [NREQ-1:0]       gnt,
  input  logic [AW-1:0]         rd_addr,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  locked,
  output logic [OW-1:0]         owner
);

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [OW-1:0]      ptr_q, ptr_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   regs_q [DEPTH];

  logic [NREQ-1:0]    gnt_s;
  logic [OW-1:0]      win_s;
  logic [OW-1:0]      idx_s;
  logic               found_s;
  logic               wr_en_s;
  logic [AW-1:0]      wr_addr_s;
  logic [WIDTH-1:0]   wr_data_s;

  // Successor of a requester index, wrapping NREQ-1 back to 0.
  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
    if (i == OW'(NREQ - 1)) begin
      return '0;
    end else begin
      return i + OW'(1);
    end
  endfunction

  // Grant selection: owner-only while locked, otherwise first requester from ptr.
  always_comb begin
    gnt_s   = '0;
    win_s   = '0;
    idx_s   = ptr_q;
    found_s = 1'b0;
    if (!rst_n) begin
      gnt_s = '0;
    end else if (state_q == ST_LOCKED) begin
      gnt_s[owner_q] = req[owner_q];
      win_s          = owner_q;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!found_s && req[idx_s]) begin
          gnt_s[idx_s] = 1'b1;
          win_s        = idx_s;
          found_s      = 1'b1;
        end else begin
          found_s = found_s;
        end
        idx_s = next_idx(idx_s);
      end
    end
  end

  assign wr_en_s   = |(req & gnt_s);
  assign wr_addr_s = wr_addr[int'(win_s)*AW +: AW];
  assign wr_data_s = wr_data[int'(win_s)*WIDTH +: WIDTH];

  // Next-state logic for arbitration pointer, lock ownership and burst count.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ARB: begin
        if (wr_en_s) begin
          if (lock[win_s]) begin
            state_d = ST_LOCKED;
            owner_d = win_s;
            cnt_d   = CW'(1);
          end else begin
            ptr_d = next_idx(win_s);
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      ST_LOCKED: begin
        // Stay locked only on a write that keeps lock and leaves room in the burst.
        if (wr_en_s && lock[owner_q] && (cnt_q != CW'(MAX_LOCK - 1))) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          state_d = ST_ARB;
          ptr_d   = next_idx(owner_q);
          owner_d = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ARB;
        ptr_d   = '0;
        owner_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Register bank: the granted write commits at the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
    end else if (wr_en_s) begin
      regs_q[wr_addr_s] <= wr_data_s;
    end
  end

  assign gnt     = gnt_s;
  assign rd_data = regs_q[rd_addr];
  assign locked  = (state_q == ST_LOCKED);
  assign owner   = owner_q;

endmodule

// File: tb/tb_rr_reg_bank_arbiter.sv
// Self-checking bench for rr_reg_bank_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the arbiter.
module tb_rr_reg_bank_arbiter;

  localparam int MAXL = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [3:0]  gnt;
  logic [1:0]  rd_addr;
  logic [3:0]  rd_data;
  logic        locked;
  logic [1:0]  owner;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  // Behavioural model state
  int         m_ptr;
  int         m_owner;
  int         m_cnt;
  bit         m_locked;
  logic [3:0] m_regs [4];

  rr_reg_bank_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .lock    (lock),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .gnt     (gnt),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .locked  (locked),
    .owner   (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_owner  = 0;
    m_cnt    = 0;
    m_locked = 1'b0;
    for (int i = 0; i < 4; i++) m_regs[i] = 4'd0;
  endtask

  function automatic int model_winner();
    if (rst_n !== 1'b1) return -1;
    if (m_locked) return (req[m_owner] ? m_owner : -1);
    for (int k = 0; k < 4; k++) begin
      if (req[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_gnt();
    logic [3:0] g;
    int w;
    g = 4'd0;
    w = model_winner();
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  task automatic model_release();
    m_ptr    = (m_owner + 1) % 4;
    m_locked = 1'b0;
    m_owner  = 0;
    m_cnt    = 0;
  endtask

  // Apply the effect of one clock edge given the inputs present before it.
  task automatic model_edge(input int w);
    if (rst_n !== 1'b1) return;
    if (w >= 0) m_regs[wr_addr[w*2 +: 2]] = wr_data[w*4 +: 4];
    if (!m_locked) begin
      if (w >= 0) begin
        if (lock[w]) begin
          m_locked = 1'b1;
          m_owner  = w;
          m_cnt    = 1;
        end else begin
          m_ptr = (w + 1) % 4;
        end
      end
    end else begin
      if (w >= 0) begin
        m_cnt++;
        if (!lock[m_owner] || m_cnt == MAXL) model_release();
      end else begin
        model_release();
      end
    end
  endtask

  task automatic check_all();
    chk("gnt", 16'(gnt), 16'(model_gnt()));
    chk("locked", 16'(locked), 16'(m_locked));
    chk("owner", 16'(owner), 16'(m_owner));
    chk("rd_data", 16'(rd_data), 16'(m_regs[rd_addr]));
  endtask

  // Inputs are driven after a falling edge; check, take the rising edge, update model.
  task automatic tick();
    int w;
    #1;
    check_all();
    w = model_winner();
    @(posedge clk);
    model_edge(w);
    @(negedge clk);
  endtask

  task automatic tick_exp(input string tag, input logic [3:0] eg);
    #1;
    chk(tag, 16'(gnt), 16'(eg));
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = 4'b1111;
    lock    = 4'b0000;
    wr_addr = {2'd3, 2'd2, 2'd1, 2'd0};
    wr_data = {4'd4, 4'd3, 4'd2, 4'd1};
    rd_addr = 2'd0;
    model_reset();

    // 1 Reset: no grant, all registers read zero; first grant after release.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_gnt", 16'(gnt), 16'h0);
    chk("rst_locked", 16'(locked), 16'h0);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      chk("rst_rd", 16'(rd_data), 16'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // 2 Rotation with all requesting.
    tick_exp("rot_gnt0", 4'b0001);
    tick_exp("rot_gnt1", 4'b0010);
    tick_exp("rot_gnt2", 4'b0100);
    tick_exp("rot_gnt3", 4'b1000);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      chk("rot_reg", 16'(rd_data), 16'(a + 1));
    end

    // 3 Fairness and wrap from ptr=3.
    req = 4'b0100;
    tick_exp("wrap_setup", 4'b0100);
    req = 4'b1001;
    tick_exp("wrap_g0", 4'b1000);
    tick_exp("wrap_g1", 4'b0001);
    tick_exp("wrap_g2", 4'b1000);

    // 4 Lock burst by requester 1 capped at MAX_LOCK, then forced release.
    req = 4'b0001;
    tick_exp("lk_setup", 4'b0001);
    req  = 4'b0011;
    lock = 4'b0010;
    tick_exp("lk_g0", 4'b0010);
    chk("lk_locked", 16'(locked), 16'h1);
    chk("lk_owner", 16'(owner), 16'h1);
    tick_exp("lk_g1", 4'b0010);
    tick_exp("lk_g2", 4'b0010);
    tick_exp("lk_g3", 4'b0010);
    chk("lk_released", 16'(locked), 16'h0);
    tick_exp("lk_after", 4'b0001);

    // 5 Early release when owner 2 drops req after two writes.
    req  = 4'b0100;
    lock = 4'b0100;
    tick_exp("er_g0", 4'b0100);
    tick_exp("er_g1", 4'b0100);
    req = 4'b0000;
    tick_exp("er_idle", 4'b0000);
    chk("er_unlocked", 16'(locked), 16'h0);
    req  = 4'b1111;
    lock = 4'b0000;
    tick_exp("er_ptr3", 4'b1000);

    // 6 Read/write collision returns the old value until the edge.
    req     = 4'b0001;
    wr_addr = {2'd3, 2'd2, 2'd1, 2'd2};
    wr_data = {4'd4, 4'd3, 4'd2, 4'd5};
    tick();
    rd_addr = 2'd2;
    wr_data = {4'd4, 4'd3, 4'd2, 4'd9};
    #1;
    chk("coll_old", 16'(rd_data), 16'h5);
    tick();
    chk("coll_new", 16'(rd_data), 16'h9);

    // Reset pulse in the middle of a locked burst.
    req  = 4'b0010;
    lock = 4'b0010;
    tick();
    chk("mid_locked", 16'(locked), 16'h1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_gnt", 16'(gnt), 16'h0);
    chk("mid_unlocked", 16'(locked), 16'h0);
    for (int a = 0; a < 4; a++) begin
      rd_addr = 2'(a);
      #1;
      chk("mid_rd", 16'(rd_data), 16'h0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        req[i]  = ($urandom_range(0, 3) != 0);
        lock[i] = ($urandom_range(0, 3) != 0);
      end
      wr_addr = 8'($urandom);
      wr_data = 16'($urandom);
      rd_addr = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
